// File: rtl/inv_key_schedule.sv
// AES-128 decryption key schedule: expands a loaded key to round 10, then steps
// backwards one round per request using the same four SBoxes in both directions.
module inv_key_schedule (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic         step,
  input  logic         rewind,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t       state_r, nxt_state_s;
  logic [127:0] round_key_r, nxt_key_s;
  logic [127:0] stored_key_r, nxt_stored_s;
  logic [3:0]   round_idx_r, nxt_idx_s;
  logic         key_ready_r, busy_r;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 32'sd0; i < 32'sd8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    gf_mul = acc;
  endfunction

  // SBox = GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 32'sd1; i < 32'sd8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    sbox = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [31:0] w0_s, w1_s, w2_s, w3_s, inv_w3_s, sbox_in_s, t_s, rc_word_s;
  logic [31:0] f0_s, f1_s, f2_s, f3_s;
  logic [3:0]  rcon_sel_s;
  logic [127:0] fwd_key_s, inv_key_s;

  assign {w0_s, w1_s, w2_s, w3_s} = round_key_r;
  assign inv_w3_s   = w3_s ^ w2_s;
  // Forward uses the next round's rcon; inverse undoes the current round's
  assign sbox_in_s  = (state_r == READY) ? inv_w3_s : w3_s;
  assign rcon_sel_s = (state_r == READY) ? round_idx_r : round_idx_r + 4'd1;
  assign rc_word_s  = {rcon(rcon_sel_s), 24'h000000};
  assign t_s = {sbox(sbox_in_s[23:16]), sbox(sbox_in_s[15:8]),
                sbox(sbox_in_s[7:0]),   sbox(sbox_in_s[31:24])};

  assign f0_s = w0_s ^ t_s ^ rc_word_s;
  assign f1_s = w1_s ^ f0_s;
  assign f2_s = w2_s ^ f1_s;
  assign f3_s = w3_s ^ f2_s;
  assign fwd_key_s = {f0_s, f1_s, f2_s, f3_s};
  assign inv_key_s = {w0_s ^ t_s ^ rc_word_s, w1_s ^ w0_s, w2_s ^ w1_s, inv_w3_s};

  // Next-state and next-key selection; load overrides everything
  always_comb begin
    nxt_state_s  = state_r;
    nxt_key_s    = round_key_r;
    nxt_stored_s = stored_key_r;
    nxt_idx_s    = round_idx_r;
    if (load) begin
      nxt_key_s   = key_in;
      nxt_idx_s   = 4'd0;
      nxt_state_s = EXPAND;
    end else begin
      case (state_r)
        IDLE: begin
          nxt_state_s = IDLE;
        end
        EXPAND: begin
          nxt_key_s = fwd_key_s;
          nxt_idx_s = round_idx_r + 4'd1;
          if (round_idx_r == 4'd9) begin
            nxt_stored_s = fwd_key_s;
            nxt_state_s  = READY;
          end else begin
            nxt_state_s = EXPAND;
          end
        end
        READY: begin
          if (rewind) begin
            nxt_key_s = stored_key_r;
            nxt_idx_s = 4'd10;
          end else if (step && (round_idx_r != 4'd0)) begin
            nxt_key_s = inv_key_s;
            nxt_idx_s = round_idx_r - 4'd1;
          end else begin
            nxt_key_s = round_key_r;
          end
        end
        default: begin
          nxt_state_s = IDLE;
        end
      endcase
    end
  end

  // State, key and status registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      round_key_r  <= 128'd0;
      stored_key_r <= 128'd0;
      round_idx_r  <= 4'd0;
      key_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= nxt_state_s;
      round_key_r  <= nxt_key_s;
      stored_key_r <= nxt_stored_s;
      round_idx_r  <= nxt_idx_s;
      key_ready_r  <= (nxt_state_s == READY);
      busy_r       <= (nxt_state_s == EXPAND);
    end
  end

  assign round_key = round_key_r;
  assign round_idx = round_idx_r;
  assign key_ready = key_ready_r;
  assign busy      = busy_r;

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Decryption-side AES-128 key schedule: expands a loaded cipher key forward to the round-10 key, then walks the schedule backwards one round per request, presenting round keys 10, 9, … 0. It feeds the inverse AddRoundKey stage of the decryption datapath. It uses four shared SBox instances for both directions and keeps the round-10 key so the next block can rewind without re-expanding.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- n_rst  in  1  asynchronous active-low reset.
- load  in  1  capture key_in and start forward expansion; honoured in any state.
- key_in  in  128  cipher key; [127:96] = w0, [31:0] = w3; byte order per FIPS-197.
- step  in  1  replace the current key with the previous round's key; READY only.
- rewind  in  1  restore the stored round-10 key; READY only.
- round_key  out  128  current round key; registered.
- round_idx  out  4  round number of round_key (0..10).
- key_ready  out  1  high in READY; round_key/round_idx valid.
- busy  out  1  high in EXPAND.

## Operation
- Reset values: state IDLE, round_key 0, stored round-10 key 0, round_idx 0, key_ready 0, busy 0.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex), placed in the top byte of a 32-bit word.
- Forward step, with K = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)), where the SBox inputs are w3 bytes [23:16],[15:8],[7:0],[31:24].
  - w0' = w0^t^{rcon[r],24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Inverse step, from round-r key {w0',w1',w2',w3'}:
  - w3 = w3'^w2'; w2 = w2'^w1'; w1 = w1'^w0'.
  - w0 = w0'^SubWord(RotWord(w3))^{rcon[r],24'h0}.
- SBox input mux: the current w3 in EXPAND; the computed w3 (w3'^w2') in READY. No other SBoxes exist.
- States:
  - IDLE: no key. step and rewind are ignored. load → EXPAND.
  - EXPAND: on each edge, round_key ← forward(round_key, rcon[round_idx+1]) and round_idx++. On the edge that makes round_idx 10, the result is also written to the stored round-10 key and the state becomes READY.
  - READY, with priority load > rewind > step:
    - rewind: round_key ← stored key, round_idx ← 10.
    - step with round_idx > 0: round_key ← inverse(round_key, rcon[round_idx]), round_idx--.
    - step with round_idx = 0: ignored; all outputs hold.
- load, in any state including mid-EXPAND: round_key ← key_in, round_idx ← 0, state EXPAND. This restarts expansion and discards any prior result.
- step and rewind are level-sampled each cycle. Holding step high walks one round per cycle down to 0, then holds.

## Timing
- Edge at which load is sampled = E0. round_key = key_in and busy = 1 after E0.
- Ten further edges E1..E10 produce rounds 1..10. After E10: key_ready = 1, busy = 0, round_idx = 10, round_key = round-10 key.
- Load-to-ready latency is 11 edges inclusive of E0.
- round_key is visible during EXPAND but is meaningful only when key_ready = 1.
- step and rewind each take one cycle: the new round_key/round_idx are visible after the sampling edge.
- A reset assertion at any point forces the reset values immediately, asynchronously. Any expansion in progress is lost and rewind has nothing to restore until a new load completes.

## Test plan
- Expand: reset, then load with key_in = 2b7e151628aed2a6abf7158809cf4f3c.
  - busy high for 10 cycles.
  - After E10: key_ready = 1, round_idx = 10, round_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Full inverse walk: from the expand result, hold step high for 10 cycles.
  - After 1 step: round_idx = 9, round_key = ac7766f319fadc2128d12941575c006e.
  - After 9 steps: round_key = a0fafe1788542cb123a339392a6c7605.
  - After 10 steps: round_idx = 0, round_key = 2b7e151628aed2a6abf7158809cf4f3c.
  - An 11th step changes nothing.
- Rewind: after walking to round 4, pulse rewind together with step.
  - rewind wins: round_idx = 10, round_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - This completes in 1 cycle with busy = 0 throughout.
- Load mid-expansion: load key A; at the 5th EXPAND cycle load key 000102030405060708090a0b0c0d0e0f.
  - round_idx restarts at 0.
  - Exactly 10 cycles later: round_key = 13111d7fe3944a17f307a78b4d2b30c5.
- Ignored inputs and reset: step or rewind in IDLE and in EXPAND leave the state and outputs unchanged.
  - Assert n_rst low mid-walk: all outputs 0 immediately.
  - rewind after reset stays in IDLE with key_ready = 0.
